// File: rtl/alu.sv
// Registered 16-opcode ALU with single-cycle latency.
// Optional Carry/Zero flag outputs are built when ALU_FLAGS_EN is defined.
module alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       opcode,
`ifdef ALU_FLAGS_EN
    output logic             Carry,
    output logic             Zero,
`endif
    output logic [WIDTH-1:0] ALU_Out
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_result;
    logic [WIDTH-1:0] r_out;

    assign w_sum  = A + B;
    assign w_diff = A - B;
    assign w_prod = A * B;
    assign w_quot = (B == '0) ? '1 : (A / B);

    // Operation decode; every opcode is defined.
    always_comb begin
        w_result = '0;
        unique case (opcode)
            4'b0000: w_result = w_sum;
            4'b0001: w_result = w_diff;
            4'b0010: w_result = w_prod;
            4'b0011: w_result = w_quot;
            4'b0100: w_result = {A[WIDTH-2:0], 1'b0};
            4'b0101: w_result = {1'b0, A[WIDTH-1:1]};
            4'b0110: w_result = {A[WIDTH-2:0], A[WIDTH-1]};
            4'b0111: w_result = {A[0], A[WIDTH-1:1]};
            4'b1000: w_result = A & B;
            4'b1001: w_result = A | B;
            4'b1010: w_result = A ^ B;
            4'b1011: w_result = ~(A | B);
            4'b1100: w_result = ~(A & B);
            4'b1101: w_result = ~(A ^ B);
            4'b1110: w_result = (A > B) ? ONE : '0;
            4'b1111: w_result = (A == B) ? ONE : '0;
            default: w_result = '0;
        endcase
    end

    // Result register; reset clears it without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out <= '0;
        end else begin
            r_out <= w_result;
        end
    end

    assign ALU_Out = r_out;

`ifdef ALU_FLAGS_EN
    logic [WIDTH:0] w_add_full;
    logic           w_carry;
    logic           r_carry;
    logic           r_zero;

    assign w_add_full = {1'b0, A} + {1'b0, B};

    // Carry source depends on the operation; others report no carry.
    always_comb begin
        w_carry = 1'b0;
        unique case (opcode)
            4'b0000: w_carry = w_add_full[WIDTH];
            4'b0001: w_carry = (A < B);
            4'b0100: w_carry = A[WIDTH-1];
            4'b0101: w_carry = A[0];
            default: w_carry = 1'b0;
        endcase
    end

    // Flags update on the same edge as the result register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            r_carry <= w_carry;
            r_zero  <= (w_result == '0);
        end
    end

    assign Carry = r_carry;
    assign Zero  = r_zero;
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases, reset behaviour,
// input hold between edges, and random operands against a reference model.
`timescale 1ns/1ps
module tb_alu;

    logic       clk;
    logic       reset;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] opcode;
    logic [7:0] ALU_Out;
`ifdef ALU_FLAGS_EN
    logic       Carry;
    logic       Zero;
`endif

    int checks;
    int failures;

    alu #(.WIDTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .A       (A),
        .B       (B),
        .opcode  (opcode),
`ifdef ALU_FLAGS_EN
        .Carry   (Carry),
        .Zero    (Zero),
`endif
        .ALU_Out (ALU_Out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic reference: results computed with plain integer math.
    function automatic int ref_result(input int a, input int b, input int op);
        int r;
        case (op)
            0:  r = (a + b) % 256;
            1:  r = (a - b + 256) % 256;
            2:  r = (a * b) % 256;
            3:  r = (b == 0) ? 255 : a / b;
            4:  r = (a * 2) % 256;
            5:  r = a / 2;
            6:  r = (a * 2) % 256 + a / 128;
            7:  r = a / 2 + (a % 2) * 128;
            8:  r = a & b;
            9:  r = a | b;
            10: r = a ^ b;
            11: r = 255 - (a | b);
            12: r = 255 - (a & b);
            13: r = 255 - (a ^ b);
            14: r = (a > b) ? 1 : 0;
            default: r = (a == b) ? 1 : 0;
        endcase
        return r;
    endfunction

    function automatic int ref_carry(input int a, input int b, input int op);
        int c;
        case (op)
            0: c = (a + b > 255) ? 1 : 0;
            1: c = (a < b) ? 1 : 0;
            4: c = (a >= 128) ? 1 : 0;
            5: c = a % 2;
            default: c = 0;
        endcase
        return c;
    endfunction

    task automatic drive(input int a, input int b, input int op);
        @(negedge clk);
        A = 8'(a);
        B = 8'(b);
        opcode = 4'(op);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        A = 8'h00;
        B = 8'h00;
        opcode = 4'h0;
        #1;
        checks++;
        if (ALU_Out !== 8'h00) begin
            failures++;
            $display("FAIL reset_initial got=%h exp=00", ALU_Out);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ALU_Out !== 8'h00) begin
            failures++;
            $display("FAIL reset_held got=%h exp=00", ALU_Out);
        end
`ifdef ALU_FLAGS_EN
        checks++;
        if (Carry !== 1'b0 || Zero !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b%b exp=00", Carry, Zero);
        end
`endif
        @(negedge clk);
        reset = 1'b0;
        A = 8'h01;
        B = 8'h01;
        opcode = 4'h0;
        #1;
        checks++;
        if (ALU_Out !== 8'h00) begin
            failures++;
            $display("FAIL pre_first_edge got=%h exp=00", ALU_Out);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ALU_Out !== 8'h02) begin
            failures++;
            $display("FAIL first_edge_add got=%h exp=02", ALU_Out);
        end
    endtask

    task automatic test_directed();
        int ta[19] = '{'hFF, 'h05, 'h10, 'h0A, 'h0A, 'h81, 'h81, 'h81,
                       'h81, 'hC3, 'hC3, 'hC3, 'hC3, 'hC3, 'hC3, 'h05,
                       'h05, 'h00, 'hFF};
        int tb[19] = '{'h01, 'h07, 'h10, 'h03, 'h00, 'h00, 'h00, 'h00,
                       'h00, 'h0F, 'h0F, 'h0F, 'h0F, 'h0F, 'h0F, 'h05,
                       'h05, 'h01, 'hFF};
        int to[19] = '{0, 1, 2, 3, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13,
                       14, 15, 1, 2};
        int te[19] = '{'h00, 'hFE, 'h00, 'h03, 'hFF, 'h02, 'h40, 'h03,
                       'hC0, 'h03, 'hCF, 'hCC, 'h30, 'hFC, 'h33, 'h00,
                       'h01, 'hFF, 'h01};
        for (int i = 0; i < 19; i++) begin
            drive(ta[i], tb[i], to[i]);
            checks++;
            if (ALU_Out !== 8'(te[i])) begin
                failures++;
                $display("FAIL directed_%0d op=%0d got=%h exp=%h",
                         i, to[i], ALU_Out, 8'(te[i]));
            end
`ifdef ALU_FLAGS_EN
            checks++;
            if (Carry !== 1'(ref_carry(ta[i], tb[i], to[i])) ||
                Zero !== (te[i] == 0)) begin
                failures++;
                $display("FAIL directed_flags_%0d got=%b%b exp=%b%b", i,
                         Carry, Zero, 1'(ref_carry(ta[i], tb[i], to[i])),
                         te[i] == 0);
            end
`endif
        end
    endtask

    task automatic test_hold();
        logic [7:0] held;
        drive('h37, 'h21, 0);
        held = ALU_Out;
        checks++;
        if (held !== 8'h58) begin
            failures++;
            $display("FAIL hold_setup got=%h exp=58", held);
        end
        #2;
        A = 8'hAA;
        B = 8'h55;
        opcode = 4'h9;
        #3;
        checks++;
        if (ALU_Out !== 8'h58) begin
            failures++;
            $display("FAIL hold_between_edges got=%h exp=58", ALU_Out);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ALU_Out !== 8'hFF) begin
            failures++;
            $display("FAIL hold_next_edge got=%h exp=ff", ALU_Out);
        end
    endtask

    task automatic test_reset_mid();
        drive('h01, 'h01, 0);
        checks++;
        if (ALU_Out !== 8'h02) begin
            failures++;
            $display("FAIL midreset_setup got=%h exp=02", ALU_Out);
        end
        #2;
        reset = 1'b1;
        A = 8'h40;
        B = 8'h02;
        opcode = 4'h0;
        #1;
        checks++;
        if (ALU_Out !== 8'h00) begin
            failures++;
            $display("FAIL midreset_async got=%h exp=00", ALU_Out);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (ALU_Out !== 8'h00) begin
                failures++;
                $display("FAIL midreset_hold_%0d got=%h exp=00", i, ALU_Out);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        A = 8'h03;
        B = 8'h04;
        @(posedge clk);
        #1;
        checks++;
        if (ALU_Out !== 8'h07) begin
            failures++;
            $display("FAIL midreset_release got=%h exp=07", ALU_Out);
        end
    endtask

    task automatic test_random();
        int a;
        int b;
        int op;
        int e;
        for (int i = 0; i < 300; i++) begin
            a = int'($urandom_range(0, 255));
            b = (i % 16 == 3) ? 0 : int'($urandom_range(0, 255));
            op = (i < 32) ? (i % 16) : int'($urandom_range(0, 15));
            e = ref_result(a, b, op);
            drive(a, b, op);
            checks++;
            if (ALU_Out !== 8'(e)) begin
                failures++;
                $display("FAIL random_%0d a=%h b=%h op=%0d got=%h exp=%h",
                         i, 8'(a), 8'(b), op, ALU_Out, 8'(e));
            end
`ifdef ALU_FLAGS_EN
            checks++;
            if (Carry !== 1'(ref_carry(a, b, op)) || Zero !== (e == 0)) begin
                failures++;
                $display("FAIL random_flags_%0d op=%0d got=%b%b exp=%b%b",
                         i, op, Carry, Zero, 1'(ref_carry(a, b, op)), e == 0);
            end
`endif
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_directed();
        test_hold();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
